// File: rtl/dice_roller_multi_if.sv
// Request/result bundle between the pin wrapper and the dice roller core.
// roll_req and seed_load are taken only in a cycle where busy is low and are dropped (not queued) while busy is high; die_valid, done and err are single-cycle strobes with no back-pressure.
interface dice_roller_multi_if #(
    parameter int SIDES_W = 5,
    parameter int LFSR_W  = 16,
    parameter int SUM_W   = SIDES_W + 4
);
    logic               roll_req;
    logic [3:0]         num_dice;
    logic [SIDES_W-1:0] sides;
    logic               seed_load;
    logic [LFSR_W-1:0]  seed;
    logic               busy;
    logic               die_valid;
    logic [SIDES_W-1:0] die_val;
    logic [3:0]         die_idx;
    logic               done;
    logic [SUM_W-1:0]   sum;
    logic               err;

    modport master (
        output roll_req, num_dice, sides, seed_load, seed,
        input  busy, die_valid, die_val, die_idx, done, sum, err
    );

    modport slave (
        input  roll_req, num_dice, sides, seed_load, seed,
        output busy, die_valid, die_val, die_idx, done, sum, err
    );
endinterface

// File: rtl/dice_roller_multi.sv
// Multi-die roller: free-running Galois LFSR, rejection sampling per die,
// streams each face value and keeps a running total of the roll.
module dice_roller_multi #(
    parameter int MAX_DICE = 4,
    parameter int SIDES_W  = 5,
    parameter int LFSR_W   = 16,
    parameter int SUM_W    = SIDES_W + 4
) (
    input  logic                clk,
    input  logic                rst,
    dice_roller_multi_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LFSR_W-1:0] LFSR_TAPS =
        (LFSR_W == 8)  ? LFSR_W'(32'h0000_00B8) :
        (LFSR_W == 24) ? LFSR_W'(32'h00E1_0000) :
        (LFSR_W == 32) ? LFSR_W'(32'hA300_0000) :
                         LFSR_W'(32'h0000_B400);
    localparam logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(32'h0000_ACE1);
    localparam logic [3:0]        MAX_N     = 4'(MAX_DICE);

    state_t             r_state, w_state_next;
    logic [LFSR_W-1:0]  r_lfsr, w_lfsr_next;
    logic [3:0]         r_num, r_cnt, r_die_idx;
    logic [SIDES_W-1:0] r_sides, r_die_val;
    logic [SUM_W-1:0]   r_sum;
    logic               r_busy, r_die_valid, r_done, r_err;
    logic               w_idle_ready, w_cfg_bad, w_accept, w_seed_take, w_draw_ok;
    logic [SIDES_W-1:0] w_mask, w_draw, w_face;

    // Smallest all-ones value covering sides-1, so a draw is rejected with p < 1/2.
    function automatic logic [SIDES_W-1:0] face_mask(input logic [SIDES_W-1:0] s);
        logic [SIDES_W-1:0] v;
        logic [SIDES_W-1:0] m;
        v = s - SIDES_W'(1);
        m = '0;
        for (int i = 0; i < SIDES_W; i++) begin
            m[i] = |(v >> i);
        end
        return m;
    endfunction

    // The done cycle sits in IDLE with busy still high, so requests wait one more cycle.
    assign w_idle_ready = (r_state == S_IDLE) && !r_busy;
    assign w_cfg_bad    = (bus.num_dice == 4'd0) || (bus.num_dice > MAX_N) ||
                          (bus.sides < SIDES_W'(2));
    assign w_accept     = w_idle_ready && bus.roll_req && !w_cfg_bad;
    assign w_seed_take  = w_idle_ready && bus.seed_load;
    assign w_mask       = face_mask(r_sides);
    assign w_draw       = r_lfsr[SIDES_W-1:0] & w_mask;
    assign w_draw_ok    = (r_state == S_ROLL) && (w_draw < r_sides);
    assign w_face       = w_draw + SIDES_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ROLL;
            S_ROLL:  if (w_draw_ok && ((r_cnt + 4'd1) == r_num)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
        if (w_seed_take) begin
            w_lfsr_next = (bus.seed == '0) ? LFSR_INIT : bus.seed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= LFSR_INIT;
            r_num       <= '0;
            r_sides     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_die_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_die_val   <= '0;
            r_die_idx   <= '0;
            r_sum       <= '0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_busy      <= (w_state_next != S_IDLE) || (r_state == S_DONE);
            r_die_valid <= w_draw_ok;
            r_done      <= (r_state == S_DONE);
            r_err       <= w_idle_ready && bus.roll_req && w_cfg_bad;
            if (w_accept) begin
                r_num   <= bus.num_dice;
                r_sides <= bus.sides;
                r_cnt   <= '0;
                r_sum   <= '0;
            end
            if (w_draw_ok) begin
                r_die_val <= w_face;
                r_die_idx <= r_cnt;
                r_cnt     <= r_cnt + 4'd1;
                r_sum     <= r_sum + SUM_W'(w_face);
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.die_valid = r_die_valid;
    assign bus.die_val   = r_die_val;
    assign bus.die_idx   = r_die_idx;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.err       = r_err;
    assign o_dbg_state   = r_state;
endmodule
